// File: rtl/click_classifier.sv
// click_classifier
//   Turns debounced one-cycle press pulses into single / double / triple click
//   events. A sequence stays open while each new press arrives within
//   GAP_CYCLES cycles of the previous one. A third press closes it at once as
//   a triple. Otherwise the window expiring closes it as a single or a double.
//
// Ports
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   press_i    one-cycle press pulse from the debouncer
//   single_o   one-cycle pulse: single click classified
//   double_o   one-cycle pulse: double click classified
//   triple_o   one-cycle pulse: triple click classified
//   busy_o     high while a sequence is open
//   last_o     last event code (0 none, 1 single, 2 double, 3 triple)
//   evt_cnt_o  number of classified events, wrapping at 2^CNT_W
module click_classifier #(
  parameter int GAP_CYCLES = 12_500_000,
  parameter int TMR_W      = 24,
  parameter int CNT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             press_i,
  output logic             single_o,
  output logic             double_o,
  output logic             triple_o,
  output logic             busy_o,
  output logic [1:0]       last_o,
  output logic [CNT_W-1:0] evt_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ONE  = 2'd1;
  localparam logic [1:0] TWO  = 2'd2;

  localparam logic [1:0] EVT_SINGLE = 2'd1;
  localparam logic [1:0] EVT_DOUBLE = 2'd2;
  localparam logic [1:0] EVT_TRIPLE = 2'd3;

  // Final timer value inside the window. The timeout fires on the edge that
  // sees this value, which is the GAP_CYCLES-th edge after the last press.
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q,  state_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             triple_q, triple_d;
  logic             busy_q,   busy_d;
  logic [1:0]       last_q,   last_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    triple_d = 1'b0;
    last_d   = last_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (press_i) begin
          state_d = ONE;
          timer_d = '0;
        end
      end

      ONE: begin
        // The press is tested before the timeout, so a press landing on the
        // timeout edge extends the sequence instead of closing it.
        if (press_i) begin
          state_d = TWO;
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          state_d  = IDLE;
          timer_d  = '0;
          single_d = 1'b1;
          last_d   = EVT_SINGLE;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      TWO: begin
        if (press_i) begin
          state_d  = IDLE;
          timer_d  = '0;
          triple_d = 1'b1;
          last_d   = EVT_TRIPLE;
          cnt_d    = cnt_q + CNT_W'(1);
        end else if (timer_q == GAP_LAST) begin
          state_d  = IDLE;
          timer_d  = '0;
          double_d = 1'b1;
          last_d   = EVT_DOUBLE;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Registered from the next state so busy falls on the same edge the
    // event pulse rises.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      triple_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 2'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      single_q <= single_d;
      double_q <= double_d;
      triple_q <= triple_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign single_o  = single_q;
  assign double_o  = double_q;
  assign triple_o  = triple_q;
  assign busy_o    = busy_q;
  assign last_o    = last_q;
  assign evt_cnt_o = cnt_q;

endmodule
